// File: rtl/splitter_valve_seq.sv
// splitter_valve_seq: ratio-based droplet splitter sequencing two outlet valves through open and settle windows.
module splitter_valve_seq #(
    parameter int OPEN_CYCLES   = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int RATIO_W       = 4,
    parameter int CNT_W         = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [RATIO_W-1:0] split_a,
    input  logic [RATIO_W-1:0] split_b,
    input  logic               ds_ready_a,
    input  logic               ds_ready_b,
    output logic               valve_a,
    output logic               valve_b,
    output logic               busy,
    input  logic               clr_cnt,
    output logic [CNT_W-1:0]   cnt_a,
    output logic [CNT_W-1:0]   cnt_b
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_OPEN   = 2'd2;
    localparam logic [1:0] S_SETTLE = 2'd3;
    logic [1:0]         r_state;
    logic               r_run;
    logic               r_phase;
    logic               r_tgt;
    logic               r_valve_a;
    logic               r_valve_b;
    logic [RATIO_W-1:0] r_pcnt;
    logic [7:0]         r_tmr;
    logic [CNT_W-1:0]   r_cnt_a;
    logic [CNT_W-1:0]   r_cnt_b;
    logic               w_acc;
    logic               w_tgt;
    logic               w_wrap;
    logic               w_sel;
    logic               w_rdy;
    logic               w_open;
    logic               w_done;
    logic [RATIO_W-1:0] w_cur;
    logic [RATIO_W-1:0] w_oth;
    logic [RATIO_W-1:0] w_rat;
    logic [RATIO_W:0]   w_pinc;
    assign in_ready = r_run && r_state == S_IDLE;
    assign busy     = r_state != S_IDLE;
    assign valve_a  = r_valve_a;
    assign valve_b  = r_valve_b;
    assign cnt_a    = r_cnt_a;
    assign cnt_b    = r_cnt_b;
    always_comb begin
        w_acc  = in_valid && in_ready;
        w_cur  = r_phase ? split_b : split_a;
        w_oth  = r_phase ? split_a : split_b;
        // An empty phase hands over to the other outlet; with both ratios zero the phase simply alternates
        w_tgt  = (w_cur == '0 && w_oth != '0) ? ~r_phase : r_phase;
        w_rat  = w_tgt ? split_b : split_a;
        w_pinc = {1'b0, r_pcnt} + (RATIO_W+1)'(1);
        w_wrap = w_pinc >= {1'b0, w_rat};
        w_sel  = r_state == S_WAIT ? r_tgt : w_tgt;
        w_rdy  = w_sel ? ds_ready_b : ds_ready_a;
        w_open = w_rdy && ((r_state == S_IDLE && w_acc) || r_state == S_WAIT);
        w_done = r_tmr == '0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_run     <= 1'b0;
            r_phase   <= 1'b0;
            r_tgt     <= 1'b0;
            r_pcnt    <= '0;
            r_tmr     <= '0;
            r_valve_a <= 1'b0;
            r_valve_b <= 1'b0;
            r_cnt_a   <= '0;
            r_cnt_b   <= '0;
        end else begin
            r_run <= 1'b1;
            if (w_acc) begin
                r_tgt   <= w_tgt;
                r_phase <= w_wrap ? ~w_tgt : w_tgt;
                r_pcnt  <= w_wrap ? '0 : w_pinc[RATIO_W-1:0];
            end
            r_valve_a <= w_open ? ~w_sel : (r_state == S_OPEN && !w_done && r_valve_a);
            r_valve_b <= w_open ? w_sel : (r_state == S_OPEN && !w_done && r_valve_b);
            r_cnt_a   <= clr_cnt ? '0 : r_cnt_a + CNT_W'(w_open && !w_sel);
            r_cnt_b   <= clr_cnt ? '0 : r_cnt_b + CNT_W'(w_open && w_sel);
            r_tmr     <= w_open ? 8'(OPEN_CYCLES - 1) :
                         (r_state == S_OPEN && w_done) ? 8'(SETTLE_CYCLES - 1) :
                         (w_done || r_state == S_IDLE || r_state == S_WAIT) ? r_tmr : r_tmr - 8'd1;
            case (r_state)
                S_IDLE:  if (w_acc) r_state <= w_open ? S_OPEN : S_WAIT;
                S_WAIT:  if (w_open) r_state <= S_OPEN;
                S_OPEN:  if (w_done) r_state <= SETTLE_CYCLES == 0 ? S_IDLE : S_SETTLE;
                default: if (w_done) r_state <= S_IDLE;
            endcase
        end
    end
endmodule
